sweep_acq_controller: RTL and testbench

- Sequencer behind SWEEP_ACQ_MODE. Steps one 10-bit DAC code from StartDac to EndDac.
- At each code it reloads the MICROROC slow-control and runs a normal acquisition until a set number of packages arrive.
- Writes a tagged header per point into the USB FIFO path. Drives the sweep-side inputs of the mode switcher.

---
 rtl/sweep_acq_controller.sv | 229 ++++++++++++++++++++++
 tb/tb_sweep_acq_controller.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_acq_controller.sv
// -----------------------------------------------------------------------------
// sweep_acq_controller
//
// Sequencer for the DAC sweep acquisition mode. It steps a DAC code from
// StartDac to EndDac (inclusive) in DacStep increments. For every point it:
//   1. writes a two-word header (HEADER_TAG, then the DAC code) into the
//      USB FIFO path,
//   2. pulses the MICROROC slow-control load and waits for the chip to
//      report that the configuration has been shifted in,
//   3. runs a normal acquisition until MaxPackageNumber package words arrive,
//   4. idles SETTLE_CYCLES cycles before moving on.
// Once the last point is done, SweepAcqDone is held until SweepStart falls.
// Dropping SweepStart during a sweep aborts it and returns to IDLE.
//
// Optional feature (macro SWEEP_ACQ_TIMEOUT_EN):
//   An acquisition that does not collect its packages within TIMEOUT_CYCLES
//   is closed. The word 16'hDEAD is written to the FIFO path and the
//   sequence continues with the settle phase.
//
// Ports:
//   Clk, Reset                       clock, synchronous active-high reset
//   SweepStart                       rise starts a sweep, low aborts/releases
//   StartDac, EndDac, DacStep        sweep range, latched at start
//   MaxPackageNumber                 packages per point, latched at start
//   MicrorocConfigDone               pulse: slow-control shift finished
//   ParallelData_en                  pulse per acquired package word
//   UsbFifoFull                      stalls header writes
//   SweepAcq10BitDac                 current DAC code
//   SweepAcqMicrorocSCParameterLoad  one-cycle slow-control load pulse
//   SweepAcqMicrorocAcqStartStop     acquisition enable level
//   SweepAcqData, SweepAcqData_en    header word and its write strobe
//   SweepTestUsbStartStop            USB readout enable (high outside IDLE)
//   SweepAcqDone                     sweep finished
// -----------------------------------------------------------------------------
module sweep_acq_controller #(
   parameter int          DAC_WIDTH     = 10,
   parameter int          SETTLE_CYCLES = 16,
   parameter logic [15:0] HEADER_TAG    = 16'h5A5A
`ifdef SWEEP_ACQ_TIMEOUT_EN
   , parameter logic [31:0] TIMEOUT_CYCLES = 32'd40_000_000
`endif
) (
   input  logic                 Clk,
   input  logic                 Reset,
   input  logic                 SweepStart,
   input  logic [DAC_WIDTH-1:0] StartDac,
   input  logic [DAC_WIDTH-1:0] EndDac,
   input  logic [DAC_WIDTH-1:0] DacStep,
   input  logic [15:0]          MaxPackageNumber,
   input  logic                 MicrorocConfigDone,
   input  logic                 ParallelData_en,
   input  logic                 UsbFifoFull,
   output logic [DAC_WIDTH-1:0] SweepAcq10BitDac,
   output logic                 SweepAcqMicrorocSCParameterLoad,
   output logic                 SweepAcqMicrorocAcqStartStop,
   output logic [15:0]          SweepAcqData,
   output logic                 SweepAcqData_en,
   output logic                 SweepTestUsbStartStop,
   output logic                 SweepAcqDone
);

   typedef enum logic [3:0] {
      IDLE,
      HDR0,
      HDR1,
      LOAD,
      WAIT_SC,
      ACQ,
      SETTLE,
      NEXT,
      DONE,
      TMO
   } state_t;

   localparam logic [15:0]          SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
   localparam logic [DAC_WIDTH-1:0] STEP_ONE    = {{(DAC_WIDTH-1){1'b0}}, 1'b1};
`ifdef SWEEP_ACQ_TIMEOUT_EN
   localparam logic [15:0]          TIMEOUT_TAG = 16'hDEAD;
`endif

   state_t               state;
   state_t               next_state;
   logic                 start_q;
   logic [DAC_WIDTH-1:0] dac;
   logic [DAC_WIDTH-1:0] end_dac;
   logic [DAC_WIDTH-1:0] step;
   logic [15:0]          max_pkg;
   logic [15:0]          pkg_cnt;
   logic [15:0]          settle_cnt;
`ifdef SWEEP_ACQ_TIMEOUT_EN
   logic [31:0]          timeout_cnt;
`endif

   logic                 start_rise;
   logic                 abort;
   logic                 pkg_hit;
   logic                 settle_hit;
   logic [DAC_WIDTH:0]   dac_sum;
   logic [15:0]          dac_word;

   assign start_rise = SweepStart & ~start_q;
   // DONE is excluded: there a low SweepStart is the normal release.
   assign abort      = ~SweepStart && (state != IDLE) && (state != DONE);
   // The pulse that completes the count closes the acquisition this cycle.
   assign pkg_hit    = ParallelData_en && ((pkg_cnt + 16'd1) == max_pkg);
   assign settle_hit = (settle_cnt == SETTLE_LAST);
   // One extra bit so a step past the top code is seen instead of wrapping.
   assign dac_sum    = {1'b0, dac} + {1'b0, step};
   assign dac_word   = {{(16-DAC_WIDTH){1'b0}}, dac};

   always_comb begin
      next_state                      = state;
      SweepAcqData                    = 16'h0000;
      SweepAcqData_en                 = 1'b0;
      SweepAcqMicrorocSCParameterLoad = 1'b0;
      SweepAcqMicrorocAcqStartStop    = 1'b0;
      SweepTestUsbStartStop           = 1'b0;
      SweepAcqDone                    = 1'b0;
      case (state)
         IDLE: begin
            if (start_rise) next_state = HDR0;
         end
         // Writes are gated by SweepStart so an aborting cycle emits nothing.
         HDR0: begin
            SweepTestUsbStartStop = 1'b1;
            if (!UsbFifoFull && SweepStart) begin
               SweepAcqData    = HEADER_TAG;
               SweepAcqData_en = 1'b1;
               next_state      = HDR1;
            end
         end
         HDR1: begin
            SweepTestUsbStartStop = 1'b1;
            if (!UsbFifoFull && SweepStart) begin
               SweepAcqData    = dac_word;
               SweepAcqData_en = 1'b1;
               next_state      = LOAD;
            end
         end
         LOAD: begin
            SweepTestUsbStartStop           = 1'b1;
            SweepAcqMicrorocSCParameterLoad = SweepStart;
            next_state                      = WAIT_SC;
         end
         WAIT_SC: begin
            SweepTestUsbStartStop = 1'b1;
            if (MicrorocConfigDone) next_state = (max_pkg == 16'd0) ? SETTLE : ACQ;
         end
         ACQ: begin
            SweepTestUsbStartStop        = 1'b1;
            SweepAcqMicrorocAcqStartStop = 1'b1;
            if (pkg_hit) next_state = SETTLE;
`ifdef SWEEP_ACQ_TIMEOUT_EN
            else if (timeout_cnt == (TIMEOUT_CYCLES - 32'd1)) next_state = TMO;
`endif
         end
`ifdef SWEEP_ACQ_TIMEOUT_EN
         TMO: begin
            SweepTestUsbStartStop = 1'b1;
            if (!UsbFifoFull && SweepStart) begin
               SweepAcqData    = TIMEOUT_TAG;
               SweepAcqData_en = 1'b1;
               next_state      = SETTLE;
            end
         end
`endif
         SETTLE: begin
            SweepTestUsbStartStop = 1'b1;
            if (settle_hit) next_state = NEXT;
         end
         NEXT: begin
            SweepTestUsbStartStop = 1'b1;
            if (dac_sum[DAC_WIDTH] || (dac_sum[DAC_WIDTH-1:0] > end_dac)) next_state = DONE;
            else next_state = HDR0;
         end
         // USB readout stays enabled so the FIFO can drain.
         DONE: begin
            SweepTestUsbStartStop = 1'b1;
            SweepAcqDone          = 1'b1;
            if (!SweepStart) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
      if (abort) next_state = IDLE;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state      <= IDLE;
         start_q    <= 1'b0;
         dac        <= '0;
         pkg_cnt    <= 16'd0;
         settle_cnt <= 16'd0;
      end else begin
         state   <= next_state;
         start_q <= SweepStart;

         if (state == IDLE && start_rise) dac <= StartDac;
         else if (next_state == IDLE) dac <= '0;
         else if (state == NEXT && next_state == HDR0) dac <= dac_sum[DAC_WIDTH-1:0];

         // Counters restart from zero whenever their state is entered.
         if (state != ACQ) pkg_cnt <= 16'd0;
         else if (ParallelData_en) pkg_cnt <= pkg_cnt + 16'd1;

         if (state != SETTLE) settle_cnt <= 16'd0;
         else settle_cnt <= settle_cnt + 16'd1;
      end
   end

`ifdef SWEEP_ACQ_TIMEOUT_EN
   always_ff @(posedge Clk) begin
      if (Reset || state != ACQ) timeout_cnt <= 32'd0;
      else timeout_cnt <= timeout_cnt + 32'd1;
   end
`endif

   // Sweep configuration is captured once per start and only read afterwards.
   always_ff @(posedge Clk) begin
      if (state == IDLE && start_rise) begin
         end_dac <= EndDac;
         step    <= (DacStep == '0) ? STEP_ONE : DacStep;
         max_pkg <= MaxPackageNumber;
      end
   end

   assign SweepAcq10BitDac = dac;

endmodule

// File: tb/tb_sweep_acq_controller.sv
// -----------------------------------------------------------------------------
// tb_sweep_acq_controller
//
// Directed bench for sweep_acq_controller. The main sequence issues sweeps
// and pushes the header words each one should produce into a queue; a
// monitor pops and compares every word the DUT strobes out. A responder
// plays the chip: ConfigDone four cycles after each load pulse, and package
// pulses on alternate cycles while acquisition is enabled.
// -----------------------------------------------------------------------------
module tb_sweep_acq_controller;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        SweepStart;
   logic [9:0]  StartDac;
   logic [9:0]  EndDac;
   logic [9:0]  DacStep;
   logic [15:0] MaxPackageNumber;
   logic        MicrorocConfigDone;
   logic        ParallelData_en;
   logic        UsbFifoFull;
   logic [9:0]  SweepAcq10BitDac;
   logic        SweepAcqMicrorocSCParameterLoad;
   logic        SweepAcqMicrorocAcqStartStop;
   logic [15:0] SweepAcqData;
   logic        SweepAcqData_en;
   logic        SweepTestUsbStartStop;
   logic        SweepAcqDone;

   always #5 Clk = ~Clk;

   sweep_acq_controller #(
      .DAC_WIDTH     (10),
      .SETTLE_CYCLES (16),
      .HEADER_TAG    (16'h5A5A)
`ifdef SWEEP_ACQ_TIMEOUT_EN
      , .TIMEOUT_CYCLES (32'd50)
`endif
   ) dut (
      .Clk                             (Clk),
      .Reset                           (Reset),
      .SweepStart                      (SweepStart),
      .StartDac                        (StartDac),
      .EndDac                          (EndDac),
      .DacStep                         (DacStep),
      .MaxPackageNumber                (MaxPackageNumber),
      .MicrorocConfigDone              (MicrorocConfigDone),
      .ParallelData_en                 (ParallelData_en),
      .UsbFifoFull                     (UsbFifoFull),
      .SweepAcq10BitDac                (SweepAcq10BitDac),
      .SweepAcqMicrorocSCParameterLoad (SweepAcqMicrorocSCParameterLoad),
      .SweepAcqMicrorocAcqStartStop    (SweepAcqMicrorocAcqStartStop),
      .SweepAcqData                    (SweepAcqData),
      .SweepAcqData_en                 (SweepAcqData_en),
      .SweepTestUsbStartStop           (SweepTestUsbStartStop),
      .SweepAcqDone                    (SweepAcqDone)
   );

   int          checks   = 0;
   int          failures = 0;
   logic [15:0] exp_q[$];

   int   load_cnt     = 0;
   int   acq_rise     = 0;
   int   acq_run      = 0;
   int   last_acq_len = 0;
   int   stall_strobes = 0;
   bit   in_stall     = 1'b0;
   logic acq_q        = 1'b0;

   int   resp_pkgs = 0;
   int   pkgs_sent = 0;
   int   sc_delay  = 0;
   bit   phase     = 1'b0;
   logic acq_prev  = 1'b0;

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual,
                  expected, expected);
      end
   endtask

   task automatic monitor_loop();
      logic [15:0] e;
      forever begin
         @(negedge Clk);
         if (!Reset) begin
            if (SweepAcqData_en) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL hdr_unexpected: got word 0x%04h, expected no write", SweepAcqData);
               end else begin
                  e = exp_q.pop_front();
                  check("hdr_word", int'(SweepAcqData), int'(e));
               end
               if (in_stall) stall_strobes++;
            end
            if (SweepAcqMicrorocSCParameterLoad) load_cnt++;
            if (SweepAcqMicrorocAcqStartStop && !acq_q) acq_rise++;
            if (SweepAcqMicrorocAcqStartStop) acq_run++;
            else if (acq_q) begin
               last_acq_len = acq_run;
               acq_run      = 0;
            end
         end
         acq_q = SweepAcqMicrorocAcqStartStop;
      end
   endtask

   task automatic responder_loop();
      forever begin
         @(posedge Clk);
         #1;
         MicrorocConfigDone = 1'b0;
         ParallelData_en    = 1'b0;
         if (sc_delay > 0) begin
            sc_delay--;
            if (sc_delay == 0) MicrorocConfigDone = 1'b1;
         end
         if (SweepAcqMicrorocSCParameterLoad) sc_delay = 4;
         if (SweepAcqMicrorocAcqStartStop) begin
            if (!acq_prev) begin
               pkgs_sent = 0;
               phase     = 1'b0;
            end
            if (!phase && pkgs_sent < resp_pkgs) begin
               ParallelData_en = 1'b1;
               pkgs_sent++;
            end
            phase = ~phase;
         end
         acq_prev = SweepAcqMicrorocAcqStartStop;
      end
   endtask

   // One full sweep: expected headers are queued up front, then the sweep
   // runs to Done and is released.
   task automatic run_sweep(input string tag, input int s, input int e, input int st,
                            input int mx, input int pkgs, input int stall, input bit tmo,
                            input int npts, input int p0, input int p1, input int p2,
                            input int exp_acq);
      int pts[3];
      int load0;
      int acq0;
      int n;
      pts[0] = p0;
      pts[1] = p1;
      pts[2] = p2;
      for (int i = 0; i < npts; i++) begin
         exp_q.push_back(16'h5A5A);
         exp_q.push_back(16'(pts[i]));
         if (tmo) exp_q.push_back(16'hDEAD);
      end
      load0 = load_cnt;
      acq0  = acq_rise;
      @(posedge Clk);
      #1;
      StartDac         = 10'(s);
      EndDac           = 10'(e);
      DacStep          = 10'(st);
      MaxPackageNumber = 16'(mx);
      resp_pkgs        = pkgs;
      SweepStart       = 1'b1;
      if (stall > 0) begin
         UsbFifoFull   = 1'b1;
         in_stall      = 1'b1;
         stall_strobes = 0;
         repeat (stall) @(posedge Clk);
         #1;
         UsbFifoFull = 1'b0;
         in_stall    = 1'b0;
         check({tag, "_stall_strobes"}, stall_strobes, 0);
      end
      n = 0;
      while (!SweepAcqDone && n < 3000) begin
         @(negedge Clk);
         n++;
      end
      check({tag, "_done"}, int'(SweepAcqDone), 1);
      check({tag, "_last_dac"}, int'(SweepAcq10BitDac), pts[npts-1]);
      check({tag, "_usb_in_done"}, int'(SweepTestUsbStartStop), 1);
      check({tag, "_loads"}, load_cnt - load0, npts);
      check({tag, "_acq_runs"}, acq_rise - acq0, exp_acq);
      check({tag, "_hdr_left"}, exp_q.size(), 0);
      @(posedge Clk);
      #1;
      SweepStart = 1'b0;
      @(posedge Clk);
      @(negedge Clk);
      check({tag, "_done_cleared"}, int'(SweepAcqDone), 0);
      check({tag, "_usb_idle"}, int'(SweepTestUsbStartStop), 0);
   endtask

   initial begin
      int n;
      Reset              = 1'b1;
      SweepStart         = 1'b0;
      StartDac           = 10'd0;
      EndDac             = 10'd0;
      DacStep            = 10'd0;
      MaxPackageNumber   = 16'd0;
      MicrorocConfigDone = 1'b0;
      ParallelData_en    = 1'b0;
      UsbFifoFull        = 1'b0;

      fork
         monitor_loop();
         responder_loop();
      join_none

      repeat (3) @(posedge Clk);
      @(negedge Clk);
      check("reset_outputs", int'({SweepAcq10BitDac, SweepAcqMicrorocSCParameterLoad,
            SweepAcqMicrorocAcqStartStop, SweepAcqData, SweepAcqData_en,
            SweepTestUsbStartStop, SweepAcqDone}), 0);
      @(posedge Clk);
      #1;
      Reset = 1'b0;
      repeat (2) @(negedge Clk);
      check("idle_outputs", int'({SweepAcq10BitDac, SweepAcqMicrorocAcqStartStop,
            SweepAcqData_en, SweepTestUsbStartStop, SweepAcqDone}), 0);

      // Nominal: 100, 105, 110 with three packages each.
      run_sweep("nominal", 100, 110, 5, 3, 3, 0, 1'b0, 3, 100, 105, 110, 3);
      check("nominal_acq_len", last_acq_len, 5);

      // Overflow: 1020 + 8 leaves the 10-bit range, so only one point.
      run_sweep("overflow", 1020, 1023, 8, 3, 3, 0, 1'b0, 1, 1020, 0, 0, 1);

      // Zero step behaves as step 1.
      run_sweep("step0", 5, 7, 0, 2, 2, 0, 1'b0, 3, 5, 6, 7, 3);

      // Start above end: a single point at the start code.
      run_sweep("reversed", 200, 100, 1, 2, 2, 0, 1'b0, 1, 200, 0, 0, 1);

      // No packages requested: no acquisition enable at all.
      run_sweep("max0", 10, 12, 2, 0, 3, 0, 1'b0, 2, 10, 12, 0, 0);

      // FIFO full for the first ten cycles of the sweep.
      run_sweep("backpressure", 400, 400, 1, 1, 1, 10, 1'b0, 1, 400, 0, 0, 1);

      // Abort in ACQ after one of three packages.
      exp_q.push_back(16'h5A5A);
      exp_q.push_back(16'h0064);
      @(posedge Clk);
      #1;
      StartDac         = 10'd100;
      EndDac           = 10'd110;
      DacStep          = 10'd5;
      MaxPackageNumber = 16'd3;
      resp_pkgs        = 1;
      SweepStart       = 1'b1;
      n = 0;
      while (!(pkgs_sent == 1 && SweepAcqMicrorocAcqStartStop) && n < 500) begin
         @(negedge Clk);
         n++;
      end
      check("abort_reached_acq", int'(SweepAcqMicrorocAcqStartStop), 1);
      @(posedge Clk);
      #1;
      SweepStart = 1'b0;
      @(negedge Clk);
      check("abort_acq_same_cycle", int'(SweepAcqMicrorocAcqStartStop), 1);
      @(negedge Clk);
      check("abort_acq_dropped", int'(SweepAcqMicrorocAcqStartStop), 0);
      check("abort_no_done", int'(SweepAcqDone), 0);
      check("abort_usb_off", int'(SweepTestUsbStartStop), 0);
      check("abort_dac_cleared", int'(SweepAcq10BitDac), 0);
      check("abort_hdr_left", exp_q.size(), 0);
      repeat (3) @(negedge Clk);

      // Restart after the abort uses the newly latched start code.
      run_sweep("restart", 300, 300, 1, 2, 2, 0, 1'b0, 1, 300, 0, 0, 1);

`ifdef SWEEP_ACQ_TIMEOUT_EN
      // No packages arrive: each point times out after 50 ACQ cycles.
      run_sweep("timeout", 50, 51, 1, 3, 0, 0, 1'b1, 2, 50, 51, 0, 2);
      check("timeout_acq_len", last_acq_len, 50);
`endif

      repeat (5) @(posedge Clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
